// File: rtl/e203_exu_lpwb_sched.sv
// e203_exu_lpwb_sched: in-order long-pipe write-back scheduler.
// Accepts only the response tagged with the FIFO retire pointer and holds it in a one-entry stage.
module e203_exu_lpwb_sched #(
   parameter int NUM_UNITS = 2,
   parameter int ITAG_W    = 1,
   parameter int RFIDX_W   = 5,
   parameter int XLEN      = 32,
   parameter int PC_W      = 32,
   parameter int CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_UNITS-1:0]        unit_i_valid,
   output logic [NUM_UNITS-1:0]        unit_i_ready,
   input  logic [NUM_UNITS*ITAG_W-1:0] unit_i_itag,
   input  logic [NUM_UNITS*XLEN-1:0]   unit_i_wdat,
   input  logic [NUM_UNITS-1:0]        unit_i_err,
   input  logic                        oitf_empty,
   input  logic [ITAG_W-1:0]           oitf_ret_ptr,
   input  logic [RFIDX_W-1:0]          oitf_ret_rdidx,
   input  logic                        oitf_ret_rdwen,
   input  logic [PC_W-1:0]             oitf_ret_pc,
   output logic                        oitf_ret_ena,
   output logic                        wbck_o_valid,
   input  logic                        wbck_o_ready,
   output logic [XLEN-1:0]             wbck_o_wdat,
   output logic [RFIDX_W-1:0]          wbck_o_rdidx,
   output logic                        excp_o_valid,
   input  logic                        excp_o_ready,
   output logic [PC_W-1:0]             excp_o_pc,
   output logic                        sel_conflict,
   output logic [CNT_W-1:0]            stall_cnt
);
   typedef enum logic {S_EMPTY, S_FULL} state_t;
   state_t               r_state;
   logic [XLEN-1:0]      r_wdat;
   logic [RFIDX_W-1:0]   r_rdidx;
   logic [PC_W-1:0]      r_pc;
   logic                 r_err, r_rdwen;
   logic [CNT_W-1:0]     r_stall;
   logic [NUM_UNITS-1:0] w_match, w_sel;
   logic [XLEN-1:0]      w_wdat;
   logic                 w_err, w_full, w_drain, w_accept;
   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_match
      assign w_match[k] = unit_i_valid[k] & ~oitf_empty & (unit_i_itag[k*ITAG_W +: ITAG_W] == oitf_ret_ptr);
   end
   // Scan downwards so the lowest-index match is the one that sticks.
   always_comb begin
      w_sel  = '0;
      w_wdat = '0;
      w_err  = 1'b0;
      for (int k = NUM_UNITS - 1; k >= 0; k--)
         if (w_match[k]) begin
            w_sel    = '0;
            w_sel[k] = 1'b1;
            w_wdat   = unit_i_wdat[k*XLEN +: XLEN];
            w_err    = unit_i_err[k];
         end
   end
   assign w_full       = r_state == S_FULL;
   assign w_drain      = w_full & (r_err ? excp_o_ready : (~r_rdwen | wbck_o_ready));
   assign w_accept     = ~rst & (|w_match) & (~w_full | w_drain);
   assign unit_i_ready = w_accept ? w_sel : '0;
   assign oitf_ret_ena = w_accept;
   assign sel_conflict = |(w_match & (w_match - NUM_UNITS'(1)));
   assign wbck_o_valid = w_full & ~r_err & r_rdwen;
   assign excp_o_valid = w_full & r_err;
   assign wbck_o_wdat  = r_wdat;
   assign wbck_o_rdidx = r_rdidx;
   assign excp_o_pc    = r_pc;
   assign stall_cnt    = r_stall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_wdat  <= '0;
         r_rdidx <= '0;
         r_pc    <= '0;
         r_err   <= 1'b0;
         r_rdwen <= 1'b0;
         r_stall <= '0;
      end else begin
         if (w_full & ~w_drain & ~&r_stall) r_stall <= r_stall + CNT_W'(1);
         if (w_accept) begin
            r_state <= S_FULL;
            r_wdat  <= w_wdat;
            r_err   <= w_err;
            r_rdidx <= oitf_ret_rdidx;
            r_rdwen <= oitf_ret_rdwen;
            r_pc    <= oitf_ret_pc;
         end else if (w_drain) begin
            r_state <= S_EMPTY;
         end
      end
   end
endmodule

// File: tb/tb_e203_exu_lpwb_sched.sv
// tb_e203_exu_lpwb_sched: directed plan plus random traffic against a behavioural stage model.
module tb_e203_exu_lpwb_sched;
   localparam int NU = 2, IW = 1, RW = 5, XL = 32, PW = 32, CW = 8;
   logic            clk = 1'b0, rst = 1'b1;
   logic [NU-1:0]   uv = '0, urdy, uerr = '0;
   logic [NU*IW-1:0] utag = '0;
   logic [NU*XL-1:0] udat = '0;
   logic            empty = 1'b1, rdwen = 1'b0, ret_ena, wbck_valid, wbck_rdy = 1'b0, excp_valid, excp_rdy = 1'b0, conflict;
   logic [IW-1:0]   ptr = '0;
   logic [RW-1:0]   rdidx = '0, wbck_rdidx;
   logic [PW-1:0]   pc = '0, excp_pc;
   logic [XL-1:0]   wbck_wdat;
   logic [CW-1:0]   stall;
   int errors = 0, checks = 0;
   // model state: the one pending result, if any
   logic            m_full = 1'b0, m_err = 1'b0, m_rdwen = 1'b0;
   logic [XL-1:0]   m_wdat = '0;
   logic [RW-1:0]   m_rdidx = '0;
   logic [PW-1:0]   m_pc = '0;
   int              m_stall = 0, last_sel = -1;
   logic            last_acc = 1'b0;

   e203_exu_lpwb_sched #(.NUM_UNITS(NU), .ITAG_W(IW), .RFIDX_W(RW), .XLEN(XL), .PC_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .unit_i_valid(uv), .unit_i_ready(urdy), .unit_i_itag(utag),
      .unit_i_wdat(udat), .unit_i_err(uerr), .oitf_empty(empty), .oitf_ret_ptr(ptr),
      .oitf_ret_rdidx(rdidx), .oitf_ret_rdwen(rdwen), .oitf_ret_pc(pc), .oitf_ret_ena(ret_ena),
      .wbck_o_valid(wbck_valid), .wbck_o_ready(wbck_rdy), .wbck_o_wdat(wbck_wdat),
      .wbck_o_rdidx(wbck_rdidx), .excp_o_valid(excp_valid), .excp_o_ready(excp_rdy),
      .excp_o_pc(excp_pc), .sel_conflict(conflict), .stall_cnt(stall));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int sel, nm;
      logic drn, acc;
      if (rst) begin
         m_full = 1'b0; m_err = 1'b0; m_rdwen = 1'b0; m_wdat = '0; m_rdidx = '0; m_pc = '0; m_stall = 0;
      end
      sel = -1;
      nm = 0;
      for (int k = 0; k < NU; k++)
         if (uv[k] && !empty && utag[k*IW +: IW] == ptr) begin
            nm++;
            if (sel < 0) sel = k;
         end
      drn = m_full && (m_err ? excp_rdy : (m_rdwen ? wbck_rdy : 1'b1));
      acc = !rst && sel >= 0 && (!m_full || drn);
      chk("ready", 64'(urdy), acc ? (64'd1 << sel) : 64'd0);
      chk("ret_ena", 64'(ret_ena), 64'(acc));
      chk("conflict", 64'(conflict), 64'(nm > 1));
      chk("wbck_valid", 64'(wbck_valid), 64'(m_full && !m_err && m_rdwen));
      chk("excp_valid", 64'(excp_valid), 64'(m_full && m_err));
      chk("stall_cnt", 64'(stall), 64'(m_stall));
      if (m_full && !m_err && m_rdwen) begin
         chk("wbck_wdat", 64'(wbck_wdat), 64'(m_wdat));
         chk("wbck_rdidx", 64'(wbck_rdidx), 64'(m_rdidx));
      end
      if (m_full && m_err) chk("excp_pc", 64'(excp_pc), 64'(m_pc));
      if (!rst) begin
         if (m_full && !drn && m_stall < 255) m_stall++;
         if (acc) begin
            m_full = 1'b1; m_wdat = udat[sel*XL +: XL]; m_err = uerr[sel];
            m_rdidx = rdidx; m_rdwen = rdwen; m_pc = pc;
         end else if (drn) m_full = 1'b0;
      end
      last_acc = acc;
      last_sel = sel;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; uv = '0; uerr = '0; empty = 1'b0; ptr = '0; rdwen = 1'b1; rdidx = '0; pc = '0;
      wbck_rdy = 1'b1; excp_rdy = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      // single accept
      rdidx = 5'd5; uv = 2'b10; utag = 2'b00; udat = {32'hDEADBEEF, 32'h0};
      #2 chk("t1_ready", 64'(urdy), 64'h2); chk("t1_ena", 64'(ret_ena), 64'h1);
      step(); uv = '0; ptr = 1'b1;
      #2 chk("t1_wvalid", 64'(wbck_valid), 64'h1); chk("t1_rdidx", 64'(wbck_rdidx), 64'h5);
      chk("t1_wdat", 64'(wbck_wdat), 64'hDEADBEEF);
      step();
      #2 chk("t1_empty", 64'(wbck_valid), 64'h0);
      // out-of-order hold-off
      do_reset();
      uv = 2'b11; utag = 2'b01; udat = {32'h11111111, 32'h22222222};
      #2 chk("t2_ready0", 64'(urdy), 64'h2);
      step(); uv = 2'b01; ptr = 1'b1;
      #2 chk("t2_ready1", 64'(urdy), 64'h1); chk("t2_wdat0", 64'(wbck_wdat), 64'h11111111);
      step(); uv = '0; ptr = 1'b0;
      #2 chk("t2_wdat1", 64'(wbck_wdat), 64'h22222222); chk("t2_wvalid", 64'(wbck_valid), 64'h1);
      // back-pressure
      do_reset();
      wbck_rdy = 1'b0; uv = 2'b01; utag = 2'b00; udat = {32'h0, 32'hA5A5A5A5};
      step(); uv = 2'b10; utag = 2'b10; udat = {32'h5A5A5A5A, 32'h0}; ptr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2 chk("t3_ready", 64'(urdy), 64'h0); chk("t3_ena", 64'(ret_ena), 64'h0);
         step();
      end
      wbck_rdy = 1'b1;
      #2 chk("t3_stall", 64'(stall), 64'h4); chk("t3_ready2", 64'(urdy), 64'h2); chk("t3_ena2", 64'(ret_ena), 64'h1);
      step(); uv = '0; ptr = 1'b0;
      #2 chk("t3_wdat2", 64'(wbck_wdat), 64'h5A5A5A5A);
      // exception path
      do_reset();
      excp_rdy = 1'b0; uv = 2'b01; utag = 2'b00; uerr = 2'b01; pc = 32'h8000_0010;
      step(); uv = '0; uerr = '0; ptr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2 chk("t4_evalid", 64'(excp_valid), 64'h1); chk("t4_pc", 64'(excp_pc), 64'h80000010);
         chk("t4_wvalid", 64'(wbck_valid), 64'h0);
         step();
      end
      excp_rdy = 1'b1;
      step();
      #2 chk("t4_drained", 64'(excp_valid), 64'h0);
      // no-write and empty FIFO
      do_reset();
      rdwen = 1'b0; uv = 2'b01; utag = 2'b00;
      #2 chk("t5_ena", 64'(ret_ena), 64'h1);
      step(); uv = '0; ptr = 1'b1;
      #2 chk("t5_wvalid", 64'(wbck_valid), 64'h0); chk("t5_evalid", 64'(excp_valid), 64'h0);
      step(); empty = 1'b1; uv = 2'b11; utag = 2'b11;
      #2 chk("t5_empty_ready", 64'(urdy), 64'h0); chk("t5_empty_ena", 64'(ret_ena), 64'h0);
      // reset while full, then saturation
      do_reset();
      wbck_rdy = 1'b0; uv = 2'b01; utag = 2'b00; udat = {32'h0, 32'hCAFEF00D};
      step(); ptr = 1'b1; uv = 2'b10; utag = 2'b10;
      #2 chk("t6_wvalid", 64'(wbck_valid), 64'h1);
      rst = 1'b1;
      #1 chk("t6_rst_wvalid", 64'(wbck_valid), 64'h0); chk("t6_rst_ready", 64'(urdy), 64'h0);
      chk("t6_rst_ena", 64'(ret_ena), 64'h0); chk("t6_rst_stall", 64'(stall), 64'h0);
      step();
      rst = 1'b0; uv = 2'b01; utag = 2'b00; ptr = 1'b0;
      step(); uv = '0; ptr = 1'b1;
      for (int i = 0; i < 300; i++) step();
      #2 chk("t6_sat", 64'(stall), 64'd255);
      // random traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         step();
         if (c == 2000) rst = 1'b1;
         if (c == 2001) rst = 1'b0;
         if (last_acc) begin
            ptr = ptr + 1'b1;
            rdidx = RW'($urandom); rdwen = ($urandom % 4) != 0; pc = $urandom;
            uv[last_sel] = 1'b0;
         end
         for (int k = 0; k < NU; k++)
            if ((!uv[k] && $urandom % 2 == 0) || (uv[k] && $urandom % 16 == 0)) begin
               uv[k] = 1'b1; utag[k*IW +: IW] = IW'($urandom);
               udat[k*XL +: XL] = $urandom; uerr[k] = ($urandom % 8) == 0;
            end
         empty = ($urandom % 8) == 0;
         wbck_rdy = ($urandom % 4) != 0;
         excp_rdy = ($urandom % 4) != 0;
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
